run_pattern_gen: RTL and testbench



---
 rtl/run_pattern_pkg.sv | 18 +
 rtl/run_detect_model.sv | 32 +++
 rtl/run_pattern_gen.sv | 136 +++++++++++++
 tb/tb_run_pattern_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/run_pattern_pkg.sv
// Shared types and constants for the run pattern generator and its
// reference run-detector model.
package run_pattern_pkg;

    // Default width of run_len, gap_len, bursts and their counters.
    localparam int RP_CNT_W = 4;

    // Number of consecutive ones the detector looks for; also the
    // depth of the history register behind exp_y.
    localparam int RUN_DET_LEN = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } rp_state_t;

endpackage

// File: rtl/run_detect_model.sv
// Golden model of the consecutive-ones run detector.
// Ports: clk, rst (sync, active-high), x (serial bit in),
//        exp_y (1 when the last RUN_DET_LEN samples of x were all 1).
module run_detect_model
    import run_pattern_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic exp_y
);

    logic [RUN_DET_LEN-1:0] hist_q;
    logic [RUN_DET_LEN-1:0] hist_d;

    // Newest sample enters at bit 0; keeps shifting at all times so
    // the prediction drains naturally once x drops.
    always_comb begin
        hist_d = {hist_q[RUN_DET_LEN-2:0], x};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign exp_y = &hist_q;

endmodule

// File: rtl/run_pattern_gen.sv
// Serial pattern source: bursts x (run_len ones + gap_len zeros).
// Ports: clk, rst, start, run_len, gap_len, bursts in;
//        x, busy, done, exp_y (predicted detector output) out.
module run_pattern_gen
    import run_pattern_pkg::*;
#(
    parameter int CNT_W = RP_CNT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] run_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] bursts,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic             exp_y
);

    rp_state_t        state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             empty;

    // Zero-length pattern: no bursts, or bursts of nothing.
    assign empty = (bursts == '0) ||
                   ((run_len == '0) && (gap_len == '0));

    // cnt_q holds the cycles left in the current phase, including the
    // current one; bcnt_q holds bursts left, including the current one.
    // Phases of length zero are skipped, so neither counter wraps.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    run_d  = run_len;
                    gap_d  = gap_len;
                    bcnt_d = bursts;
                    if (empty) begin
                        done_d = 1'b1;
                    end else if (run_len != '0) begin
                        state_d = RUN;
                        cnt_d   = run_len;
                    end else begin
                        state_d = GAP;
                        cnt_d   = gap_len;
                    end
                end
            end
            RUN: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (gap_q != '0) begin
                    state_d = GAP;
                    cnt_d   = gap_q;
                end else if (bcnt_q > CNT_W'(1)) begin
                    bcnt_d = bcnt_q - CNT_W'(1);
                    cnt_d  = run_q;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bcnt_q > CNT_W'(1)) begin
                    bcnt_d = bcnt_q - CNT_W'(1);
                    if (run_q != '0) begin
                        state_d = RUN;
                        cnt_d   = run_q;
                    end else begin
                        cnt_d = gap_q;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the next state.
        x_d    = (state_d == RUN);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    run_detect_model u_model (
        .clk   (clk),
        .rst   (rst),
        .x     (x_q),
        .exp_y (exp_y)
    );

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Scoreboard bench for run_pattern_gen: directed patterns with
// hand-written per-cycle expectations of x, busy, done and exp_y.
module tb_run_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] run_len;
    logic [3:0] gap_len;
    logic [3:0] bursts;
    logic       x;
    logic       busy;
    logic       done;
    logic       exp_y;

    always #5 clk = ~clk;

    run_pattern_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .run_len (run_len),
        .gap_len (gap_len),
        .bursts  (bursts),
        .x       (x),
        .busy    (busy),
        .done    (done),
        .exp_y   (exp_y)
    );

    typedef struct {
        string name;
        int    cyc;
        logic  x;
        logic  busy;
        logic  done;
        logic  y;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int cyc, input string sig,
                       input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d %s got %b want %b",
                     nm, cyc, sig, got, want);
        end
    endtask

    // Monitor: one expected entry per cycle while the queue is non-empty.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk(e.name, e.cyc, "x", x, e.x);
                chk(e.name, e.cyc, "busy", busy, e.busy);
                chk(e.name, e.cyc, "done", done, e.done);
                chk(e.name, e.cyc, "exp_y", exp_y, e.y);
            end
        end
    end

    // String of n chars, '1' at indices lo..hi.
    function automatic string rng(input int n, input int lo, input int hi);
        string s;
        s = "";
        for (int i = 0; i < n; i++) begin
            if (i >= lo && i <= hi) s = {s, "1"};
            else s = {s, "0"};
        end
        return s;
    endfunction

    // Cycle 0 is the cycle in which start is first high.
    task automatic run_test(input string nm,
                            input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b,
                            input int hold, input int rst_at,
                            input bit scr,
                            input string xs, input string bs,
                            input string ds, input string ys);
        int   n;
        exp_t e;
        n = xs.len();
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            e.name = nm;
            e.cyc  = i;
            e.x    = (xs[i] == "1");
            e.busy = (bs[i] == "1");
            e.done = (ds[i] == "1");
            e.y    = (ys[i] == "1");
            sbq.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start = (k < hold);
            rst   = (k == rst_at);
            if (k == 0 || !scr) begin
                run_len = r;
                gap_len = g;
                bursts  = b;
            end else begin
                run_len = 4'($urandom);
                gap_len = 4'($urandom);
                bursts  = 4'($urandom);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s drain left %0d want 0", nm, sbq.size());
            sbq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst     = 1'b1;
        start   = 1'b0;
        run_len = '0;
        gap_len = '0;
        bursts  = '0;
        repeat (2) @(posedge clk);
        #1;
        e.name = "reset";
        e.cyc  = 0;
        e.x    = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.y    = 1'b0;
        sbq.push_back(e);
        start = 1'b1;
        run_len = 4'd4;
        gap_len = 4'd2;
        bursts  = 4'd2;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_test("nominal", 4'd4, 4'd2, 4'd2, 1, -1, 1'b0,
                 "011110011110000", "011111111111100",
                 "000000000000010", "000011000011000");

        run_test("opchange", 4'd4, 4'd2, 4'd2, 1, -1, 1'b1,
                 "011110011110000", "011111111111100",
                 "000000000000010", "000011000011000");

        run_test("short", 4'd2, 4'd1, 4'd3, 1, -1, 1'b0,
                 "011011011000", "011111111100",
                 "000000000010", "000000000000");

        run_test("zerobursts", 4'd3, 4'd2, 4'd0, 1, -1, 1'b0,
                 "0000", "0000", "0100", "0000");

        run_test("zerorun", 4'd0, 4'd3, 4'd1, 1, -1, 1'b0,
                 "000000", "011100", "000010", "000000");

        run_test("maxrun", 4'd15, 4'd0, 4'd2, 1, -1, 1'b0,
                 rng(35, 1, 30), rng(35, 1, 30),
                 rng(35, 31, 31), rng(35, 4, 31));

        run_test("backtoback", 4'd1, 4'd1, 4'd1, 7, -1, 1'b0,
                 "01001001000", "01101101100",
                 "00010010010", "00000000000");

        run_test("midreset", 4'd4, 4'd2, 4'd2, 1, 3, 1'b0,
                 rng(17, 1, 3), rng(17, 1, 3),
                 rng(17, -1, -1), rng(17, -1, -1));

        run_test("afterreset", 4'd2, 4'd1, 4'd3, 1, -1, 1'b0,
                 "011011011000", "011111111100",
                 "000000000010", "000000000000");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
